// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch, data and memory bus bundle for mem_arbiter
//
// Fetch port   : f_req, f_addr (in); f_ack, f_rdata (out)
// Data port    : d_req, d_we, d_addr, d_wdata, d_be (in); d_ack, d_rdata (out)
// Memory port  : mem_rdata (in); mem_en, mem_we, mem_addr, mem_wdata, mem_be (out)
// Status       : busy, owner (out)
// Directions above are as seen by the arbiter (master modport). The slave
// modport is the requester/memory side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  f_req;
    logic [ADDR_W-1:0]     f_addr;
    logic                  f_ack;
    logic [DATA_W-1:0]     f_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic [DATA_W/8-1:0]   d_be;
    logic                  d_ack;
    logic [DATA_W-1:0]     d_rdata;

    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_be;
    logic [DATA_W-1:0]     mem_rdata;

    logic                  busy;
    logic                  owner;

    modport master (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
        output f_ack, f_rdata, d_ack, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, mem_be, busy, owner
    );

    modport slave (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
        input  f_ack, f_rdata, d_ack, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, mem_be, busy, owner
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port fetch/data arbiter and sequencer for unified memory
//
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-low
//   bus   : mem_arbiter_if.master (fetch port, data port, memory port, busy/owner)
// Parameters: MEM_LATENCY (1..15), ADDR_W, DATA_W.
// Optional feature: define MEM_ARB_RR_EN for round-robin tie breaking;
// otherwise data wins every tie and no pointer register exists.
// All outputs come straight from registers.
module mem_arbiter #(
    parameter int MEM_LATENCY = 1,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, CMD, WAIT, ACK} state_t;

    state_t state, state_nx;
    logic   grant;
    logic   grant_data;
    logic   capture;

    logic [3:0]          cnt;
    logic                f_ack_q, d_ack_q, mem_en_q, mem_we_q, busy_q, owner_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q, f_rdata_q, d_rdata_q;
    logic [DATA_W/8-1:0] mem_be_q;

`ifdef MEM_ARB_RR_EN
    // 1 = data was granted last; resets so the first tie goes to fetch.
    logic last_data;

    always_ff @(posedge clk) begin
        if (!reset) begin
            last_data <= 1'b1;
        end else if (grant) begin
            last_data <= grant_data;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        grant      = 1'b0;
        grant_data = 1'b0;
        case (state)
            IDLE: begin
                if (bus.f_req || bus.d_req) begin
                    grant    = 1'b1;
                    state_nx = CMD;
`ifdef MEM_ARB_RR_EN
                    grant_data = bus.d_req && (!bus.f_req || !last_data);
`else
                    grant_data = bus.d_req;
`endif
                end
            end
            CMD:     state_nx = WAIT;
            WAIT:    if (cnt == 4'd0) state_nx = ACK;
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Read data is valid during the last WAIT cycle; stores skip the capture.
    assign capture = (state == WAIT) && (cnt == 4'd0) && !mem_we_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt         <= 4'd0;
            f_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            owner_q     <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            f_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            // Outputs are registered from the next state so they line up
            // with the state they belong to.
            mem_en_q <= (state_nx == CMD);
            busy_q   <= (state_nx != IDLE);
            f_ack_q  <= (state_nx == ACK) && !owner_q;
            d_ack_q  <= (state_nx == ACK) && owner_q;

            if (grant) begin
                owner_q     <= grant_data;
                mem_addr_q  <= grant_data ? bus.d_addr : bus.f_addr;
                mem_we_q    <= grant_data && bus.d_we;
                mem_wdata_q <= grant_data ? bus.d_wdata : '0;
                mem_be_q    <= grant_data ? bus.d_be : '0;
            end

            if (state == CMD) begin
                cnt <= 4'(MEM_LATENCY - 1);
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end

            if (capture) begin
                if (owner_q) begin
                    d_rdata_q <= bus.mem_rdata;
                end else begin
                    f_rdata_q <= bus.mem_rdata;
                end
            end
        end
    end

    assign bus.f_ack     = f_ack_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.f_rdata   = f_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.busy      = busy_q;
    assign bus.owner     = owner_q;
endmodule
